// File: rtl/thor2022_vec_alu_seq.sv
// Vector element sequencer: issues one lane per clock to the shared scalar ALU and assembles the result vector.
// Optional build macro THOR2022_VSEQ_SKIP_MASKED_EN: skip issuing masked-off lanes and resolve them at accept.
module thor2022_vec_alu_seq #(
    parameter int unsigned NLANES  = 8,
    parameter int unsigned LANEW   = 64,
    parameter int unsigned ALU_LAT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [6:0]                req_vl,
    input  logic [NLANES-1:0]         req_mask,
    input  logic                      req_zero,
    input  logic [3:0]                req_tag,
    input  logic [NLANES*LANEW-1:0]   req_va,
    input  logic [NLANES*LANEW-1:0]   req_vb,
    input  logic [NLANES*LANEW-1:0]   req_vc,
    input  logic [NLANES*LANEW-1:0]   req_vt,
    output logic                      alu_issue,
    output logic [LANEW-1:0]          alu_xa,
    output logic [LANEW-1:0]          alu_xb,
    output logic [LANEW-1:0]          alu_xc,
    output logic [LANEW-1:0]          alu_t,
    output logic                      alu_m,
    output logic                      alu_z,
    input  logic [LANEW-1:0]          alu_res,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [NLANES*LANEW-1:0]   res_vec,
    output logic [3:0]                res_tag,
    output logic                      busy,
    input  logic                      abort
);

    localparam int unsigned VW  = NLANES * LANEW;
    localparam int unsigned LW  = $clog2(NLANES);
    localparam int unsigned NW  = $clog2(NLANES) + 1;
    localparam int unsigned DRW = 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LW-1:0]       r_lane;
    logic [VW-1:0]       r_va;
    logic [VW-1:0]       r_vb;
    logic [VW-1:0]       r_vc;
    logic [VW-1:0]       r_vec;
    logic [NLANES-1:0]   r_mask;
    logic                r_zero;
    logic [3:0]          r_tag;
    logic [DRW-1:0]      r_drain;

    logic                w_accept;
    logic                w_kill;
    logic [NW-1:0]       w_req_n;
    logic                w_go_issue;
    logic [LW-1:0]       w_start_lane;
    logic [LW-1:0]       w_next_lane;
    logic                w_last;
    logic [VW-1:0]       w_preset;
    logic                w_cap_v;
    logic [LW-1:0]       w_cap_idx;

    assign w_accept = req_valid & req_ready;
    assign w_kill   = abort & (r_state != S_IDLE);
    assign w_req_n  = (req_vl > 7'(NLANES)) ? NW'(NLANES) : NW'(req_vl);

`ifdef THOR2022_VSEQ_SKIP_MASKED_EN
    logic [NLANES-1:0]   r_emask;
    logic [NLANES-1:0]   w_req_emask;
    logic [LW:0]         w_first;
    logic [LW:0]         w_nxt;

    // Lowest set bit of m at or above index from; MSB of the result flags a hit.
    function automatic logic [LW:0] first_set(input logic [NLANES-1:0] m, input int from);
        logic [LW:0] res;
        res = '0;
        for (int i = NLANES - 1; i >= 0; i--) begin
            if (m[i] && (i >= from)) res = {1'b1, LW'(i)};
        end
        return res;
    endfunction

    always_comb begin
        w_req_emask = '0;
        w_preset    = req_vt;
        for (int i = 0; i < NLANES; i++) begin
            if (NW'(i) < w_req_n) begin
                w_req_emask[i] = req_mask[i];
                if (!req_mask[i] && req_zero) w_preset[i*LANEW +: LANEW] = '0;
            end
        end
    end

    assign w_first      = first_set(w_req_emask, 0);
    assign w_go_issue   = w_first[LW];
    assign w_start_lane = w_first[LW-1:0];
    assign w_nxt        = first_set(r_emask, int'(r_lane) + 1);
    assign w_last       = ~w_nxt[LW];
    assign w_next_lane  = w_nxt[LW-1:0];

    always_ff @(posedge clk) begin
        if (rst)           r_emask <= '0;
        else if (w_accept) r_emask <= w_req_emask;
    end
`else
    logic [NW-1:0]       r_n;

    assign w_go_issue   = (w_req_n != '0);
    assign w_start_lane = '0;
    assign w_last       = (r_lane == LW'(r_n - NW'(1)));
    assign w_next_lane  = r_lane + LW'(1);
    assign w_preset     = req_vt;

    always_ff @(posedge clk) begin
        if (rst)           r_n <= '0;
        else if (w_accept) r_n <= w_req_n;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_go_issue ? S_ISSUE : S_DONE;
            S_ISSUE: if (w_last) w_state_nxt = (ALU_LAT > 0) ? S_DRAIN : S_DONE;
            S_DRAIN: if (r_drain == '0) w_state_nxt = S_DONE;
            S_DONE:  if (res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_kill) w_state_nxt = S_IDLE;
    end

    // Old target for lane i is read from r_vec: that lane is never overwritten before it issues.
    always_comb begin
        req_ready = (r_state == S_IDLE) & ~rst;
        busy      = (r_state != S_IDLE);
        res_valid = (r_state == S_DONE);
        alu_issue = 1'b0;
        alu_xa    = '0;
        alu_xb    = '0;
        alu_xc    = '0;
        alu_t     = '0;
        alu_m     = 1'b0;
        alu_z     = 1'b0;
        if (r_state == S_ISSUE) begin
            alu_issue = 1'b1;
            alu_xa    = r_va[r_lane*LANEW +: LANEW];
            alu_xb    = r_vb[r_lane*LANEW +: LANEW];
            alu_xc    = r_vc[r_lane*LANEW +: LANEW];
            alu_t     = r_vec[r_lane*LANEW +: LANEW];
            alu_m     = r_mask[r_lane];
            alu_z     = r_zero;
        end
    end

    assign res_vec = r_vec;
    assign res_tag = r_tag;

    generate
        if (ALU_LAT == 0) begin : g_cap_comb
            assign w_cap_v   = (r_state == S_ISSUE);
            assign w_cap_idx = r_lane;
        end else begin : g_cap_pipe
            logic [ALU_LAT-1:0] r_pv;
            logic [LW-1:0]      r_pidx [ALU_LAT];

            // Lane-index shift pipeline matching the ALU latency; flushed on abort.
            always_ff @(posedge clk) begin
                if (rst || w_kill) begin
                    r_pv <= '0;
                    for (int k = 0; k < ALU_LAT; k++) r_pidx[k] <= '0;
                end else begin
                    r_pv[0]   <= (r_state == S_ISSUE);
                    r_pidx[0] <= r_lane;
                    for (int k = 1; k < ALU_LAT; k++) begin
                        r_pv[k]   <= r_pv[k-1];
                        r_pidx[k] <= r_pidx[k-1];
                    end
                end
            end

            assign w_cap_v   = r_pv[ALU_LAT-1];
            assign w_cap_idx = r_pidx[ALU_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane  <= '0;
            r_va    <= '0;
            r_vb    <= '0;
            r_vc    <= '0;
            r_vec   <= '0;
            r_mask  <= '0;
            r_zero  <= 1'b0;
            r_tag   <= '0;
            r_drain <= '0;
        end else if (w_accept) begin
            r_lane  <= w_start_lane;
            r_va    <= req_va;
            r_vb    <= req_vb;
            r_vc    <= req_vc;
            r_vec   <= w_preset;
            r_mask  <= req_mask;
            r_zero  <= req_zero;
            r_tag   <= req_tag;
        end else begin
            if (r_state == S_ISSUE) begin
                r_lane <= w_next_lane;
                if (w_last) r_drain <= DRW'(ALU_LAT - 1);
            end
            if ((r_state == S_DRAIN) && (r_drain != '0)) r_drain <= r_drain - DRW'(1);
            if (w_cap_v && !w_kill) begin
                for (int i = 0; i < NLANES; i++) begin
                    if (w_cap_idx == LW'(i)) r_vec[i*LANEW +: LANEW] <= alu_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_thor2022_vec_alu_seq.sv
// Bench for thor2022_vec_alu_seq: one combinational-ALU instance and one 2-cycle-ALU instance share stimulus.
module tb_thor2022_vec_alu_seq;

    localparam int NL  = 8;
    localparam int LWD = 64;
    localparam int VW  = NL * LWD;

    typedef struct {
        logic [VW-1:0] vec;
        logic [3:0]    tag;
        int            a;
        int            lat;
        int            iss;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [6:0]    req_vl = '0;
    logic [NL-1:0] req_mask = '0;
    logic          req_zero = 1'b0;
    logic [3:0]    req_tag = '0;
    logic [VW-1:0] req_va = '0;
    logic [VW-1:0] req_vb = '0;
    logic [VW-1:0] req_vc = '0;
    logic [VW-1:0] req_vt = '0;
    logic          res_ready = 1'b1;
    logic          abort = 1'b0;

    logic           req_ready [2];
    logic           alu_issue [2];
    logic [LWD-1:0] alu_xa [2];
    logic [LWD-1:0] alu_xb [2];
    logic [LWD-1:0] alu_xc [2];
    logic [LWD-1:0] alu_t [2];
    logic [LWD-1:0] alu_res [2];
    logic           alu_m [2];
    logic           alu_z [2];
    logic           res_valid [2];
    logic [VW-1:0]  res_vec [2];
    logic [3:0]     res_tag [2];
    logic           busy [2];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   iss_cnt [2];
    logic prev_v [2];
    exp_t cur [2];
    exp_t q0 [$];
    exp_t q1 [$];
    int   lat_of [2] = '{0, 2};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LWD-1:0] alu_f(input logic [LWD-1:0] xa, input logic [LWD-1:0] xb,
                                             input logic [LWD-1:0] t, input logic m, input logic z);
        return m ? (xa + xb) : (z ? '0 : t);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        thor2022_vec_alu_seq #(.NLANES(NL), .LANEW(LWD), .ALU_LAT((g == 0) ? 0 : 2)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_ready(req_ready[g]), .req_vl(req_vl), .req_mask(req_mask),
            .req_zero(req_zero), .req_tag(req_tag),
            .req_va(req_va), .req_vb(req_vb), .req_vc(req_vc), .req_vt(req_vt),
            .alu_issue(alu_issue[g]), .alu_xa(alu_xa[g]), .alu_xb(alu_xb[g]), .alu_xc(alu_xc[g]),
            .alu_t(alu_t[g]), .alu_m(alu_m[g]), .alu_z(alu_z[g]), .alu_res(alu_res[g]),
            .res_valid(res_valid[g]), .res_ready(res_ready), .res_vec(res_vec[g]), .res_tag(res_tag[g]),
            .busy(busy[g]), .abort(abort)
        );
        if (g == 0) begin : g_alu_comb
            assign alu_res[g] = alu_f(alu_xa[g], alu_xb[g], alu_t[g], alu_m[g], alu_z[g]);
        end else begin : g_alu_pipe
            logic [LWD-1:0] p1;
            logic [LWD-1:0] p2;
            always @(posedge clk) begin
                p1 <= alu_f(alu_xa[g], alu_xb[g], alu_t[g], alu_m[g], alu_z[g]);
                p2 <= p1;
            end
            assign alu_res[g] = p2;
        end
    end

    task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] lanes(input logic [LWD-1:0] base, input logic [LWD-1:0] step);
        logic [VW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*LWD +: LWD] = base + LWD'(i) * step;
        return v;
    endfunction

    function automatic logic [VW-1:0] rvec();
        logic [VW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*LWD +: LWD] = {$urandom, $urandom};
        return v;
    endfunction

    // Result monitor: pops the scoreboard on the first res_valid cycle, then checks hold stability.
    always @(negedge clk) begin
        logic have;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (alu_issue[k]) iss_cnt[k]++;
                else check_eq($sformatf("alu_idle%0d", k),
                              VW'({alu_xa[k], alu_xb[k], alu_xc[k], alu_t[k], alu_m[k], alu_z[k]}), '0);
                if (res_valid[k]) begin
                    if (!prev_v[k]) begin
                        have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
                        check_eq($sformatf("res_expected%0d", k), VW'(have), VW'(1));
                        if (have) begin
                            if (k == 0) cur[0] = q0.pop_front();
                            else        cur[1] = q1.pop_front();
                            check_eq($sformatf("latency%0d", k), VW'(cyc - cur[k].a), VW'(cur[k].lat));
                            check_eq($sformatf("issues%0d", k), VW'(iss_cnt[k]), VW'(cur[k].iss));
                            check_eq($sformatf("res_vec%0d", k), res_vec[k], cur[k].vec);
                            check_eq($sformatf("res_tag%0d", k), VW'(res_tag[k]), VW'(cur[k].tag));
                        end
                    end else begin
                        check_eq($sformatf("hold_vec%0d", k), res_vec[k], cur[k].vec);
                        check_eq($sformatf("hold_tag%0d", k), VW'(res_tag[k]), VW'(cur[k].tag));
                        check_eq($sformatf("hold_ready%0d", k), VW'(req_ready[k]), '0);
                    end
                end else if (prev_v[k]) begin
                    check_eq($sformatf("idle_after_hs%0d", k), VW'(req_ready[k]), VW'(1));
                end
            end
        end
        for (int k = 0; k < 2; k++) prev_v[k] = res_valid[k] & ~rst;
    end

    // Caller sits at a negedge; returns at the negedge after the accept cycle.
    task automatic send(input int vl, input logic [NL-1:0] mask, input logic zero, input logic [3:0] tag,
                        input logic [VW-1:0] va, input logic [VW-1:0] vb, input logic [VW-1:0] vc,
                        input logic [VW-1:0] vt, input bit push);
        int to = 0;
        int n;
        int ni;
        exp_t e;
        while (!(req_ready[0] && req_ready[1]) && to < 300) begin
            @(negedge clk);
            to++;
        end
        if (to >= 300) check_eq("ready_timeout", VW'(req_ready[0] & req_ready[1]), VW'(1));
        req_valid = 1'b1;
        req_vl = 7'(vl);
        req_mask = mask;
        req_zero = zero;
        req_tag = tag;
        req_va = va;
        req_vb = vb;
        req_vc = vc;
        req_vt = vt;
        iss_cnt[0] = 0;
        iss_cnt[1] = 0;
        n = (vl > NL) ? NL : vl;
        e.vec = vt;
        e.tag = tag;
        e.a = cyc;
        ni = 0;
        for (int i = 0; i < n; i++) begin
            if (mask[i]) begin
                e.vec[i*LWD +: LWD] = va[i*LWD +: LWD] + vb[i*LWD +: LWD];
                ni++;
            end else if (zero) begin
                e.vec[i*LWD +: LWD] = '0;
            end
        end
`ifndef THOR2022_VSEQ_SKIP_MASKED_EN
        ni = n;
`endif
        e.iss = ni;
        if (push) begin
            e.lat = (ni == 0) ? 1 : 1 + ni + lat_of[0];
            q0.push_back(e);
            e.lat = (ni == 0) ? 1 : 1 + ni + lat_of[1];
            q1.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int to = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy[0] || busy[1]) && to < 500) begin
            @(negedge clk);
            to++;
        end
        if (to >= 500) check_eq("idle_timeout", VW'(busy[0] | busy[1]), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] va;
        logic [VW-1:0] vt;
        int to;
        for (int k = 0; k < 2; k++) begin
            iss_cnt[k] = 0;
            prev_v[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_valid%0d", k), VW'(res_valid[k]), '0);
            check_eq($sformatf("rst_vec%0d", k), res_vec[k], '0);
            check_eq($sformatf("rst_tag%0d", k), VW'(res_tag[k]), '0);
            check_eq($sformatf("rst_issue%0d", k), VW'(alu_issue[k]), '0);
            check_eq($sformatf("rst_busy%0d", k), VW'(busy[k]), '0);
            check_eq($sformatf("rst_ready%0d", k), VW'(req_ready[k]), '0);
        end
        rst = 1'b0;
        @(negedge clk);

        send(4, 8'hFF, 1'b0, 4'h3, lanes(0, 1), lanes(10, 0), rvec(), lanes(64'hAA, 0), 1'b1);
        wait_idle();
        send(8, 8'h0A, 1'b1, 4'h5, rvec(), rvec(), rvec(), rvec(), 1'b1);
        wait_idle();
        send(8, 8'h0A, 1'b0, 4'h6, rvec(), rvec(), rvec(), rvec(), 1'b1);
        wait_idle();
        send(0, 8'hFF, 1'b0, 4'h7, rvec(), rvec(), rvec(), rvec(), 1'b1);
        wait_idle();
        send(12, 8'hFF, 1'b1, 4'h8, rvec(), rvec(), rvec(), rvec(), 1'b1);
        wait_idle();
        send(3, 8'hFF, 1'b0, 4'h9, rvec(), rvec(), rvec(), rvec(), 1'b1);
        wait_idle();

        // Consumer stall: result must hold and no new op may be accepted.
        res_ready = 1'b0;
        send(5, 8'h5B, 1'b1, 4'hA, rvec(), rvec(), rvec(), rvec(), 1'b1);
        to = 0;
        while (!(res_valid[0] && res_valid[1]) && to < 100) begin
            @(negedge clk);
            to++;
        end
        if (to >= 100) check_eq("stall_valid_timeout", VW'(res_valid[0] & res_valid[1]), VW'(1));
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) check_eq($sformatf("stall_ready%0d", k), VW'(req_ready[k]), '0);
        end
        res_ready = 1'b1;
        wait_idle();

        // Abort while lane 2 is on the ALU, then an immediate follow-up op.
        va = lanes(100, 1);
        send(8, 8'hFF, 1'b0, 4'hB, va, rvec(), rvec(), rvec(), 1'b0);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        for (int k = 0; k < 2; k++) check_eq($sformatf("abort_lane2_%0d", k), VW'(alu_xa[k]), VW'(102));
        @(negedge clk);
        abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("abort_ready%0d", k), VW'(req_ready[k]), VW'(1));
            check_eq($sformatf("abort_valid%0d", k), VW'(res_valid[k]), '0);
            check_eq($sformatf("abort_busy%0d", k), VW'(busy[k]), '0);
        end
        vt = rvec();
        send(8, 8'hF7, 1'b1, 4'hC, rvec(), rvec(), rvec(), vt, 1'b1);
        wait_idle();

        // Reset mid-operation clears the result registers.
        send(6, 8'hFF, 1'b0, 4'hD, rvec(), rvec(), rvec(), rvec(), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("midrst_vec%0d", k), res_vec[k], '0);
            check_eq($sformatf("midrst_tag%0d", k), VW'(res_tag[k]), '0);
            check_eq($sformatf("midrst_busy%0d", k), VW'(busy[k]), '0);
            check_eq($sformatf("midrst_ready%0d", k), VW'(req_ready[k]), '0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 10; r++) begin
            send(int'($urandom_range(0, 12)), NL'($urandom), 1'($urandom), 4'($urandom),
                 rvec(), rvec(), rvec(), rvec(), 1'b1);
            if (r % 3 == 0) wait_idle();
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/thor2022_vec_alu_seq.md
Name: thor2022_vec_alu_seq

Overview:
- Element sequencer that runs one vector ALU instruction over the shared scalar integer ALU, one lane per clock.
- Accepts a whole vector operation, drives per-lane operands and the lane-mask and zeroing controls (m, z) to the ALU, and collects the per-lane results.
- Returns the assembled result vector with a tag.
- Sits between the vector issue stage and the scalar ALU; owns the ALU only while busy.

Parameters:
- NLANES, 8: number of vector lanes (power of two, 2..64).
- LANEW, 64: bits per lane; equals the ALU value width.
- ALU_LAT, 0: clocks from operands on alu_* outputs to valid alu_res (0 = combinational ALU); legal 0..3.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  vector op offered.
- req_ready  out  1  sequencer can accept.
- req_vl  in  7  vector length; values above NLANES are clipped to NLANES.
- req_mask  in  NLANES  per-lane enable.
- req_zero  in  1  1 = masked lanes zeroed; 0 = merge from old target.
- req_tag  in  4  op identifier.
- req_va, req_vb, req_vc  in  NLANES*LANEW  source vectors.
- req_vt  in  NLANES*LANEW  old target vector.
- alu_issue  out  1  lane operands valid this cycle.
- alu_xa, alu_xb, alu_xc, alu_t  out  LANEW  per-lane operands.
- alu_m  out  1  lane mask bit.
- alu_z  out  1  zeroing control.
- alu_res  in  LANEW  ALU result.
- res_valid  out  1  result vector valid.
- res_ready  in  1  consumer accepts result.
- res_vec  out  NLANES*LANEW  result vector.
- res_tag  out  4  tag of the completed op.
- busy  out  1  state is not IDLE.
- abort  in  1  kill the current op.

Behaviour:
- Reset: state IDLE; res_valid=0, res_vec=0, res_tag=0, alu_issue=0, alu_* = 0, busy=0. req_ready=0 while rst is high.
- req_ready = (state==IDLE) & ~rst. Accept = req_valid & req_ready at cycle A.
- At accept, register all request fields. Preset res_vec to req_vt, n = min(req_vl, NLANES), lane counter = 0.
- States:
  - IDLE: on accept go to ISSUE if n>0, else go to DONE.
  - ISSUE: lane i is driven in cycle A+1+i. alu_issue=1, alu_xa/xb/xc/alu_t = lane i of va/vb/vc/vt, alu_m=mask[i], alu_z=zero. After lane n-1 go to DRAIN if ALU_LAT>0, else go to DONE.
  - DRAIN: wait ALU_LAT cycles with alu_issue=0, then go to DONE.
  - DONE: res_valid=1. On res_ready, go to IDLE next cycle.
- Result capture: alu_res for lane i is written into res_vec lane i at the clock edge ending cycle A+1+i+ALU_LAT. Capture is tracked by a valid/lane-index shift pipeline of depth ALU_LAT.
- Lanes at or above n are never issued; they keep the req_vt value (tail undisturbed).
- Latency: res_valid first high in cycle A+1+n+ALU_LAT for n>0, and in cycle A+1 for n=0.
- When alu_issue=0, all alu_* outputs are driven to 0.
- res_vec and res_tag stay stable while res_valid=1 and res_ready=0. No new accept occurs in the cycle of the result handshake.
- abort has priority over all other events in any state. Next cycle: state IDLE, res_valid=0, capture pipeline flushed, and no later writes to res_vec. abort in IDLE is ignored.
- rst mid-operation behaves like abort and also clears res_vec and res_tag.

Optional Feature:
- Macro: THOR2022_VSEQ_SKIP_MASKED_EN.
- Defined: lanes with mask=0 are not issued. At accept they are preset to 0 if req_zero=1, else to vt. The counter advances to the next set mask bit below n. Latency is A+1+popcount(mask[n-1:0])+ALU_LAT. If no lane below n is set, behaviour equals n=0.
- Undefined: every lane below n is issued, and the ALU applies m/z itself.

Test Plan:
- ALU_LAT=0, ALU model res = m ? xa+xb : (z ? 0 : t). Inputs: vl=4, mask=0xFF, va lane i=i, vb=10, vt=0xAA -> res_vec lanes 0..3 = 10..13, lanes 4..7 = 0xAA; res_valid at A+5; tag echoed.
- vl=8, mask=0x0A, zero=1 -> lanes 1,3 = sums, other lanes 0. Repeat with zero=0 -> other lanes = vt. With SKIP_MASKED_EN, res_valid at A+3.
- vl=0 -> res_valid at A+1, res_vec=vt, alu_issue never high. vl=12 -> treated as 8, res_valid at A+9.
- ALU_LAT=2, vl=3 -> alu_issue high in A+1..A+3, res_valid at A+6, each lane written 2 cycles after issue.
- abort asserted during lane 2 issue -> no res_valid, req_ready=1 next cycle; a following op returns correct results with no stale lane writes.
- res_ready held low 3 cycles after res_valid -> res_vec/res_tag stable, req_ready low; res_ready=1 -> IDLE next cycle.
